// File: rtl/stereo_pkg.sv
// stereo_pkg: shared image geometry and disparity-to-grey mapping for the stereo pipeline
package stereo_pkg;
  localparam int IMG_W = 640;
  localparam int IMG_H = 480;
  localparam int DISP = 64;
  localparam int WA_W = 17;
  function automatic logic [7:0] grey_of(input logic [5:0] d);
    return {d, d[5:4]};
  endfunction
endpackage

// File: rtl/disp_fifo.sv
// disp_fifo: synchronous first-word-fall-through FIFO with registered valid and count
module disp_fifo #(
  parameter int DEPTH = 16,
  parameter int W = 49
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic wr, rd;
  logic [AW:0] cnt_n;
  // a push into a full FIFO lands in the slot the simultaneous pop frees
  always_comb begin
    rd = pop && valid;
    wr = push && (count != (AW+1)'(DEPTH) || rd);
    cnt_n = count + (AW+1)'(wr) - (AW+1)'(rd);
    dout = valid ? mem[rp] : '0;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      valid <= 1'b0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      count <= cnt_n;
      valid <= cnt_n != '0;
    end
  always_ff @(posedge clk)
    if (wr) mem[wp] <= din;
endmodule

// File: rtl/disparity_writer.sv
// disparity_writer: packs disparity samples into 32-bit grey words and queues them with word addresses
module disparity_writer #(
  parameter int IMG_W = stereo_pkg::IMG_W,
  parameter int IMG_H = stereo_pkg::IMG_H,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        disparity_val,
  input  logic [5:0]  disparity,
  input  logic        frame_start,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [31:0] wr_data,
  output logic [16:0] wr_addr,
  output logic        frame_done,
  output logic        overflow
);
  localparam int WA_W = stereo_pkg::WA_W;
  localparam int WORDS = IMG_W * IMG_H / 4;
  localparam int XW = IMG_W > 1 ? $clog2(IMG_W) : 1;
  localparam int YW = IMG_H > 1 ? $clog2(IMG_H) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [XW-1:0] x, x_b;
  logic [YW-1:0] y, y_b;
  logic [1:0] lane, lane_b;
  logic [WA_W-1:0] word_addr, wa_b;
  logic [23:0] part;
  logic [31:0] word;
  logic [48:0] dout;
  logic [CW-1:0] count;
  logic push, pop, full, drop, x_last;
  // frame_start takes effect before a coincident sample is counted
  always_comb begin
    x_b = frame_start ? '0 : x;
    y_b = frame_start ? '0 : y;
    lane_b = frame_start ? '0 : lane;
    wa_b = frame_start ? '0 : word_addr;
    x_last = x_b == XW'(IMG_W - 1);
    push = disparity_val && lane_b == 2'd3;
    word = {stereo_pkg::grey_of(disparity), part};
    pop = wr_valid && wr_ready;
    full = count == CW'(FIFO_DEPTH);
    drop = push && full && !pop;
    wr_data = dout[48:17];
    wr_addr = dout[16:0];
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      x <= '0;
      y <= '0;
      lane <= '0;
      word_addr <= '0;
      part <= '0;
      frame_done <= 1'b0;
      overflow <= 1'b0;
    end else begin
      frame_done <= push && wa_b == WA_W'(WORDS - 1);
      overflow <= (overflow && !frame_start) || drop;
      x <= x_b;
      y <= y_b;
      lane <= lane_b;
      word_addr <= wa_b;
      if (disparity_val) begin
        lane <= lane_b + 1'b1;
        part <= {stereo_pkg::grey_of(disparity), part[23:8]};
        x <= x_last ? '0 : x_b + 1'b1;
        if (x_last) y <= y_b == YW'(IMG_H - 1) ? '0 : y_b + 1'b1;
        if (push) word_addr <= wa_b == WA_W'(WORDS - 1) ? '0 : wa_b + 1'b1;
      end
    end
  disp_fifo #(.DEPTH(FIFO_DEPTH), .W(49)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .din({word, wa_b}),
    .pop(pop),
    .dout(dout),
    .valid(wr_valid),
    .count(count)
  );
endmodule
